// File: rtl/stack_queue_buffer_pkg.sv
// Shared mode encodings and sizing/pointer helpers for the stack/queue buffer.
package stack_queue_buffer_pkg;

  localparam logic MODE_LIFO = 1'b0;
  localparam logic MODE_FIFO = 1'b1;

  // Ceiling log2, with a minimum result of 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Wrap by explicit compare so DEPTH need not be a power of two.
  function automatic int ptr_inc(input int p, input int depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/stack_queue_buffer_buffer_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one read port registered into q.
// A read returns the pre-edge contents even when the same entry is written on that edge.
module buffer_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= re;
      if (re) q <= mem[raddr];
    end
  end

endmodule

// File: rtl/stack_queue_buffer.sv
// Run-time selectable LIFO/FIFO buffer; pop data appears in q one edge after the accepted pop.
// Rejected pushes/pops change nothing but a sticky overflow/underflow flag.
module stack_queue_buffer
  import stack_queue_buffer_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            data,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        mode,
  input  logic                        clear_err,
  output logic [WIDTH-1:0]            q,
  output logic                        q_valid,
  output logic [clog2(DEPTH+1)-1:0]   count,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_full,
  output logic                        mode_q,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [PW-1:0] wp, rp, waddr, raddr;
  logic [CW-1:0] sp, next_count;
  logic          pop_ok, push_ok, mode_chg, mem_we;

  // In LIFO mode the stack pointer is the occupancy itself.
  assign sp = count;

  always_comb begin
    pop_ok   = pop && (count != '0);
    push_ok  = push && ((count < CW'(DEPTH)) || pop_ok);
    mode_chg = (count == '0) && !push;
    mem_we   = reset && push_ok;

    next_count = count;
    if (push_ok && !pop_ok)      next_count = count + 1'b1;
    else if (pop_ok && !push_ok) next_count = count - 1'b1;

    if (mode_q == MODE_FIFO) begin
      waddr = wp;
      raddr = rp;
    end else begin
      // Push+pop replaces the top in place after it has been read out.
      raddr = PW'(sp - 1'b1);
      waddr = pop_ok ? PW'(sp - 1'b1) : PW'(sp);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count       <= '0;
      wp          <= '0;
      rp          <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      mode_q      <= MODE_LIFO;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      count       <= next_count;
      empty       <= (next_count == '0);
      full        <= (next_count == CW'(DEPTH));
      almost_full <= (next_count >= CW'(AFULL_LEVEL));
      overflow    <= (push && !push_ok) || (overflow && !clear_err);
      underflow   <= (pop && !pop_ok) || (underflow && !clear_err);

      if (mode_chg) begin
        mode_q <= mode;
        wp     <= '0;
        rp     <= '0;
      end else if (mode_q == MODE_FIFO) begin
        if (push_ok) wp <= PW'(ptr_inc(int'(wp), DEPTH));
        if (pop_ok)  rp <= PW'(ptr_inc(int'(rp), DEPTH));
      end
    end
  end

  buffer_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .we      (mem_we),
    .waddr   (waddr),
    .wdata   (data),
    .re      (pop_ok),
    .raddr   (raddr),
    .q       (q),
    .q_valid (q_valid)
  );

endmodule

// File: tb/tb_stack_queue_buffer.sv
// Directed bench for stack_queue_buffer at WIDTH=16, DEPTH=4, AFULL_LEVEL=3.
module tb_stack_queue_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data = '0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        mode = 1'b0;
  logic        clear_err = 1'b0;
  logic [15:0] q;
  logic        q_valid;
  logic [2:0]  count;
  logic        empty, full, almost_full, mode_q, overflow, underflow;

  int total = 0;
  int bad = 0;

  stack_queue_buffer #(.WIDTH(16), .DEPTH(4), .AFULL_LEVEL(3)) dut (
    .clock(clock), .reset(reset), .data(data), .push(push), .pop(pop),
    .mode(mode), .clear_err(clear_err), .q(q), .q_valid(q_valid),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full),
    .mode_q(mode_q), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock with the given request; outputs are sampled 1 time unit after the edge.
  task automatic op(input logic pu, input logic po, input logic [15:0] d, input logic ce);
    push = pu; pop = po; data = d; clear_err = ce;
    @(posedge clock);
    #1;
    push = 1'b0; pop = 1'b0; clear_err = 1'b0;
  endtask

  task automatic chk_pop(input string tag, input logic [15:0] exp_q, input logic [2:0] exp_cnt);
    op(1'b0, 1'b1, 16'h0, 1'b0);
    check({tag, "_q"}, 32'(q), 32'(exp_q));
    check({tag, "_qv"}, 32'(q_valid), 32'd1);
    check({tag, "_cnt"}, 32'(count), 32'(exp_cnt));
  endtask

  task automatic chk_reset_state(input string tag);
    check({tag, "_cnt"}, 32'(count), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_af"}, 32'(almost_full), 32'd0);
    check({tag, "_mode"}, 32'(mode_q), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_unf"}, 32'(underflow), 32'd0);
    check({tag, "_q"}, 32'(q), 32'd0);
    check({tag, "_qv"}, 32'(q_valid), 32'd0);
  endtask

  initial begin
    #1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    chk_reset_state("rst");

    // LIFO fill and drain
    op(1'b1, 1'b0, 16'h11, 1'b0);
    op(1'b1, 1'b0, 16'h22, 1'b0);
    check("lifo_af2", 32'(almost_full), 32'd0);
    op(1'b1, 1'b0, 16'h33, 1'b0);
    check("lifo_af3", 32'(almost_full), 32'd1);
    check("lifo_full3", 32'(full), 32'd0);
    op(1'b1, 1'b0, 16'h44, 1'b0);
    check("lifo_full4", 32'(full), 32'd1);
    check("lifo_cnt4", 32'(count), 32'd4);
    chk_pop("lifo_p1", 16'h44, 3'd3);
    chk_pop("lifo_p2", 16'h33, 3'd2);
    chk_pop("lifo_p3", 16'h22, 3'd1);
    chk_pop("lifo_p4", 16'h11, 3'd0);
    check("lifo_empty", 32'(empty), 32'd1);
    op(1'b0, 1'b0, 16'h0, 1'b0);
    check("idle_qv", 32'(q_valid), 32'd0);
    check("idle_qhold", 32'(q), 32'h11);

    // FIFO wrap
    mode = 1'b1;
    op(1'b0, 1'b0, 16'h0, 1'b0);
    check("mode_fifo", 32'(mode_q), 32'd1);
    op(1'b1, 1'b0, 16'h0A, 1'b0);
    op(1'b1, 1'b0, 16'h0B, 1'b0);
    op(1'b1, 1'b0, 16'h0C, 1'b0);
    chk_pop("fifo_pA", 16'h0A, 3'd2);
    chk_pop("fifo_pB", 16'h0B, 3'd1);
    op(1'b1, 1'b0, 16'h0D, 1'b0);
    op(1'b1, 1'b0, 16'h0E, 1'b0);
    op(1'b1, 1'b0, 16'h0F, 1'b0);
    check("fifo_full", 32'(full), 32'd1);
    check("fifo_cnt4", 32'(count), 32'd4);
    // Simultaneous push/pop while full
    op(1'b1, 1'b1, 16'h77, 1'b0);
    check("fifo_pp_q", 32'(q), 32'h0C);
    check("fifo_pp_cnt", 32'(count), 32'd4);
    check("fifo_pp_ovf", 32'(overflow), 32'd0);
    chk_pop("fifo_pD", 16'h0D, 3'd3);
    chk_pop("fifo_pE", 16'h0E, 3'd2);
    chk_pop("fifo_pF", 16'h0F, 3'd1);
    chk_pop("fifo_p77", 16'h77, 3'd0);

    // Underflow on empty pop, then clear
    op(1'b0, 1'b1, 16'h0, 1'b0);
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_cnt", 32'(count), 32'd0);
    check("unf_qhold", 32'(q), 32'h77);
    check("unf_qv", 32'(q_valid), 32'd0);
    op(1'b0, 1'b0, 16'h0, 1'b1);
    check("unf_clr", 32'(underflow), 32'd0);

    // Back to LIFO, simultaneous push/pop
    mode = 1'b0;
    op(1'b0, 1'b0, 16'h0, 1'b0);
    check("mode_lifo", 32'(mode_q), 32'd0);
    op(1'b1, 1'b0, 16'h11, 1'b0);
    op(1'b1, 1'b0, 16'h22, 1'b0);
    op(1'b1, 1'b1, 16'h99, 1'b0);
    check("lifo_pp_q", 32'(q), 32'h22);
    check("lifo_pp_cnt", 32'(count), 32'd2);
    chk_pop("lifo_pp_next", 16'h99, 3'd1);
    op(1'b1, 1'b0, 16'h22, 1'b0);

    // Mode gating while occupied
    mode = 1'b1;
    op(1'b0, 1'b0, 16'h0, 1'b0);
    check("mode_gated", 32'(mode_q), 32'd0);

    // Overflow with contents intact
    op(1'b1, 1'b0, 16'h33, 1'b0);
    op(1'b1, 1'b0, 16'h44, 1'b0);
    op(1'b1, 1'b0, 16'h55, 1'b0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_cnt", 32'(count), 32'd4);
    chk_pop("ovf_p1", 16'h44, 3'd3);
    chk_pop("ovf_p2", 16'h33, 3'd2);
    chk_pop("ovf_p3", 16'h22, 3'd1);
    chk_pop("ovf_p4", 16'h11, 3'd0);
    check("mode_held_last_pop", 32'(mode_q), 32'd0);
    op(1'b0, 1'b0, 16'h0, 1'b0);
    check("mode_after_drain", 32'(mode_q), 32'd1);

    // clear_err coinciding with a new underflow: set wins
    op(1'b0, 1'b1, 16'h0, 1'b1);
    check("clr_vs_unf", 32'(underflow), 32'd1);
    check("clr_ovf", 32'(overflow), 32'd0);
    op(1'b0, 1'b0, 16'h0, 1'b1);
    check("clr_unf", 32'(underflow), 32'd0);

    // Push+pop on empty: pop rejected, push accepted
    op(1'b1, 1'b1, 16'h5A, 1'b0);
    check("pe_cnt", 32'(count), 32'd1);
    check("pe_unf", 32'(underflow), 32'd1);
    check("pe_qv", 32'(q_valid), 32'd0);
    chk_pop("pe_pop", 16'h5A, 3'd0);
    op(1'b0, 1'b0, 16'h0, 1'b1);

    // Reset mid-operation
    op(1'b1, 1'b0, 16'h01, 1'b0);
    op(1'b1, 1'b0, 16'h02, 1'b0);
    op(1'b1, 1'b0, 16'h03, 1'b0);
    check("pre_rst_cnt", 32'(count), 32'd3);
    mode = 1'b0;
    reset = 1'b0;
    op(1'b0, 1'b0, 16'h0, 1'b0);
    reset = 1'b1;
    chk_reset_state("mid_rst");
    op(1'b0, 1'b1, 16'h0, 1'b0);
    check("post_rst_unf", 32'(underflow), 32'd1);
    check("post_rst_qv", 32'(q_valid), 32'd0);
    check("post_rst_q", 32'(q), 32'd0);
    check("post_rst_cnt", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_queue_buffer.md
Name: stack_queue_buffer

Overview:
Parametrised successor to the team's single-mode stack block: one storage array that operates as either a LIFO (stack) or a FIFO (queue), selected at run time.
- Adds registered read data with a valid strobe, an almost-full threshold, sticky overflow/underflow error flags, and defined simultaneous push/pop semantics in both modes.
- Sits between the datapath and control units wherever operands or return addresses are buffered.

Parameters:
WIDTH, 16, data word width in bits (>=1)
DEPTH, 16, number of entries (>=2, need not be a power of two)
AFULL_LEVEL, DEPTH-2, count at or above which almost_full asserts (1..DEPTH)

Ports:
clock  input  1  single rising-edge clock
reset  input  1  synchronous, active-low reset (0 = reset, sampled on clock edge)
data  input  WIDTH  write data, captured on an accepted push
push  input  1  write request
pop  input  1  read request
mode  input  1  requested mode: 0 = LIFO, 1 = FIFO
clear_err  input  1  clears sticky error flags
q  output  WIDTH  registered read data
q_valid  output  1  one-cycle pulse: q was updated by an accepted pop
count  output  clog2(DEPTH+1)  current occupancy 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_full  output  1  count >= AFULL_LEVEL
mode_q  output  1  active mode
overflow  output  1  sticky: push rejected
underflow  output  1  sticky: pop rejected

Behaviour:
- Reset (reset==0 at an edge):
  - count=0, all pointers=0, q=0, q_valid=0.
  - empty=1, full=0, almost_full=0, mode_q=0, overflow=0, underflow=0.
  - Memory contents are not reset.
  - Reset has priority over all other inputs.
  - Reset mid-operation discards every stored entry; the next pop after reset is an underflow.
- Acceptance, evaluated from the current-cycle count:
  - pop_ok = pop && count>0
  - push_ok = push && (count<DEPTH || pop_ok)
- Count update:
  - count+1 if push_ok && !pop_ok
  - count-1 if pop_ok && !push_ok
  - otherwise unchanged
- empty, full and almost_full are registered from next_count; they are valid in the same cycle as count.
- LIFO mode:
  - A single pointer sp equals count; the top of stack is at sp-1.
  - Push only: mem[sp] <= data.
  - Pop only: q <= mem[sp-1].
  - Push and pop together (count>0): q <= old mem[sp-1], then mem[sp-1] <= data; count unchanged. The popped value is always the pre-edge top, never the incoming data.
- FIFO mode:
  - Separate write pointer wp and read pointer rp.
  - Push: mem[wp] <= data, wp advances.
  - Pop: q <= mem[rp], rp advances.
  - Pointers wrap from DEPTH-1 to 0 by explicit compare, not bit truncation.
  - Push and pop together (count>0): both happen; count unchanged. When full, this is legal.
- Read latency: q and q_valid update on the edge where the pop is accepted, i.e. the data is visible the cycle after pop is asserted. q holds its value otherwise; q_valid=0 in cycles with no accepted pop.
- Errors:
  - overflow sets when push && !push_ok.
  - underflow sets when pop && !pop_ok.
  - Both flags are sticky until clear_err=1 or reset.
  - If clear_err and a new error coincide, the flag stays set (set wins).
  - A rejected request changes no state besides its error flag.
- Mode change:
  - mode_q <= mode only on an edge where count==0 and push==0. Otherwise mode is ignored.
  - On an accepted mode change, wp, rp and sp reset to 0.
  - Changing mode therefore never reorders stored data.
- Push when empty with pop also asserted: the pop is rejected (underflow), the push is accepted, and count becomes 1.

Decomposition:
- Shared package:
  - MODE_LIFO=1'b0, MODE_FIFO=1'b1
  - log2 helper function (ceil)
  - a pointer-increment-with-wrap function
- One sub-module, buffer_mem: DEPTH x WIDTH array with one synchronous write port, plus one synchronous read port registered into q. It receives the write and read addresses and enables from the control logic.
- Pointer, count, flag and mode logic stay in stack_queue_buffer.

Test Plan (WIDTH=16, DEPTH=4, AFULL_LEVEL=3):
- LIFO fill and drain: push 0x11,0x22,0x33,0x44 -> full=1, almost_full=1 after the 3rd push. Then pop x4 -> q=0x44,0x33,0x22,0x11, each with a one-cycle q_valid, then empty=1.
- FIFO wrap: set mode=1 while empty; push A,B,C; pop x2; push D,E,F -> full=1. Pop x4 -> q=C,D,E,F; wp/rp have wrapped with no corruption.
- Simultaneous push/pop:
  - LIFO holding 0x11,0x22: push 0x99 + pop -> q=0x22, count stays 2; next pop -> q=0x99.
  - FIFO full: push + pop -> count stays 4, q=oldest entry.
- Errors: pop when empty -> underflow=1, count=0, q unchanged. Push when full (no pop) -> overflow=1, contents intact. clear_err -> both 0. clear_err coinciding with a new underflow -> underflow stays 1.
- Mode gating: with count=2 in LIFO, drive mode=1 -> mode_q stays 0. Drain to empty, mode=1 -> mode_q=1 on the next edge.
- Reset mid-operation: count=3, assert reset=0 for one edge -> every output at its reset value. A following pop -> underflow=1 and q_valid=0.
